// File: rtl/wb_rf_pkg.sv
// Shared definitions for the architectural register file and the write-back stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register/data widths, R15 (PC) and R14 (LR) indices, write-port record.
package wb_rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_PC = 4'd15;
  localparam logic [ADDR_W-1:0] REG_LR = 4'd14;

  // One write-back port: enable, destination index, data.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wr_port_t;

  // True when idx names an implemented register.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

  // True when the port is enabled and targets idx.
  function automatic logic wr_hits(input wr_port_t p, input logic [ADDR_W-1:0] idx);
    return p.en && (p.idx == idx);
  endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// Bus bundle between write-back/decode/fetch and the register file.
// Latency: n/a (wires only).
// Backpressure: none; every write and read is accepted in the cycle it is presented.
// master: drives write ports, pc_inc, read indices; slave: returns read data, pc, collision.
interface wb_reg_file_if
  import wb_rf_pkg::*;
  ;
  logic              wr1;
  logic [ADDR_W-1:0] wr_reg1;
  logic [DATA_W-1:0] wr_data1;
  logic              wr2;
  logic [ADDR_W-1:0] wr_reg2;
  logic [DATA_W-1:0] wr_data2;
  logic              pc_inc;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] pc;
  logic              collision;

  modport master (
    output wr1, wr_reg1, wr_data1, wr2, wr_reg2, wr_data2, pc_inc,
    output rd_addr_a, rd_addr_b, rd_addr_c,
    input  rd_data_a, rd_data_b, rd_data_c, pc, collision
  );

  modport slave (
    input  wr1, wr_reg1, wr_data1, wr2, wr_reg2, wr_data2, pc_inc,
    input  rd_addr_a, rd_addr_b, rd_addr_c,
    output rd_data_a, rd_data_b, rd_data_c, pc, collision
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: array mux with optional same-cycle write forwarding.
// Latency: 0 cycles (pure combinational from register state).
// Backpressure: none.
// Ports: regs_i (register state), addr_i, wr1_i/wr2_i (write ports), data_o.
// Build option RF_BYPASS_EN: forward matching write data (wr1 over wr2).
module rf_read_port
  import wb_rf_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  wr_port_t                        wr1_i,
  input  wr_port_t                        wr2_i,
  output logic [DATA_W-1:0]               data_o
);

  always_comb begin
    data_o = '0;
    if (idx_ok(addr_i, NUM_REGS)) data_o = regs_i[addr_i];
`ifdef RF_BYPASS_EN
    // Enables arrive already qualified by index range; wr1 checked last so it wins.
    if (wr_hits(wr2_i, addr_i)) data_o = wr2_i.data;
    if (wr_hits(wr1_i, addr_i)) data_o = wr1_i.data;
`endif
  end

`ifndef RF_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr1_i, wr2_i};
`endif

endmodule

// File: rtl/wb_reg_file.sv
// Architectural register file (R15 = PC, R14 = LR) fed by the dual write-back ports.
// Latency: writes commit on the clock edge; reads are combinational (0 cycles).
// Backpressure: none; wr1 wins same-index collisions, wr2 data dropped and flagged.
// Ports: clk, reset (sync, active-high), bus (wb_reg_file_if.slave).
// Build option RF_BYPASS_EN: read ports forward same-cycle write data.
module wb_reg_file
  import wb_rf_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic         clk,
  input  logic         reset,
  wb_reg_file_if.slave bus
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic                            collision_q, collision_d;
  wr_port_t                        wp1, wp2;

  // Out-of-range indices are dropped here so neither writes nor bypass see them.
  assign wp1 = '{en: bus.wr1 && idx_ok(bus.wr_reg1, NUM_REGS), idx: bus.wr_reg1, data: bus.wr_data1};
  assign wp2 = '{en: bus.wr2 && idx_ok(bus.wr_reg2, NUM_REGS), idx: bus.wr_reg2, data: bus.wr_data2};

  always_comb begin
    regs_d = regs_q;
    // Increment first so any explicit R15 write below replaces it (branch target not bumped).
    if (bus.pc_inc) regs_d[REG_PC] = regs_q[REG_PC] + DATA_W'(PC_STEP);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hits(wp2, ADDR_W'(i))) regs_d[i] = wp2.data;
      if (wr_hits(wp1, ADDR_W'(i))) regs_d[i] = wp1.data;
    end
  end

  assign collision_d = wp1.en && wp2.en && (wp1.idx == wp2.idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q         <= '0;
      regs_q[REG_PC] <= PC_RESET;
      collision_q    <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      collision_q <= collision_d;
    end
  end

  assign bus.pc        = regs_q[REG_PC];
  assign bus.collision = collision_q;

  rf_read_port #(.NUM_REGS(NUM_REGS)) u_rd_a (
    .regs_i(regs_q), .addr_i(bus.rd_addr_a), .wr1_i(wp1), .wr2_i(wp2), .data_o(bus.rd_data_a)
  );
  rf_read_port #(.NUM_REGS(NUM_REGS)) u_rd_b (
    .regs_i(regs_q), .addr_i(bus.rd_addr_b), .wr1_i(wp1), .wr2_i(wp2), .data_o(bus.rd_data_b)
  );
  rf_read_port #(.NUM_REGS(NUM_REGS)) u_rd_c (
    .regs_i(regs_q), .addr_i(bus.rd_addr_c), .wr1_i(wp1), .wr2_i(wp2), .data_o(bus.rd_data_c)
  );

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed vector bench for wb_reg_file: reset sweep, then a table of per-cycle vectors.
// Each vector is driven after the falling edge and its outputs checked before the next rising edge.
// Expected values are hand-computed; bypass-dependent reads select via RF_BYPASS_EN.
module tb_wb_reg_file;
  import wb_rf_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  wb_reg_file_if bus ();

  wb_reg_file #(.NUM_REGS(16), .PC_RESET(16'h0000), .PC_STEP(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        w1;
    logic [3:0]  r1;
    logic [15:0] d1;
    logic        w2;
    logic [3:0]  r2;
    logic [15:0] d2;
    logic        inc;
    logic [3:0]  ra, rb, rc;
    logic [15:0] ea, eb, ec, epc;
    logic        ecol;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst, input logic w1, input logic [3:0] r1, input logic [15:0] d1,
    input logic w2, input logic [3:0] r2, input logic [15:0] d2, input logic inc,
    input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
    input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec,
    input logic [15:0] epc, input logic ecol);
    vec_t v;
    v.rst = rst; v.w1 = w1; v.r1 = r1; v.d1 = d1;
    v.w2 = w2; v.r2 = r2; v.d2 = d2; v.inc = inc;
    v.ra = ra; v.rb = rb; v.rc = rc;
    v.ea = ea; v.eb = eb; v.ec = ec; v.epc = epc; v.ecol = ecol;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.wr1 = 1'b0; bus.wr_reg1 = '0; bus.wr_data1 = '0;
    bus.wr2 = 1'b0; bus.wr_reg2 = '0; bus.wr_data2 = '0;
    bus.pc_inc = 1'b0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.rd_addr_c = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // T0 disjoint dual write; T2 branch-with-link; T4 collision; T7..T14 PC wrap and hold;
    // T15..T18 back-to-back collisions; T20 reset against writes/pc_inc; T22 idle writes to R0.
    vecs[0]  = mk(0, 1, 4'd3, 16'h1234, 1, 4'd5, 16'hBEEF, 0, 4'd3, 4'd5, REG_PC,
                  BYP ? 16'h1234 : 16'h0000, BYP ? 16'hBEEF : 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd3, 4'd5, 4'd0,
                  16'h1234, 16'hBEEF, 16'h0000, 16'h0000, 0);
    vecs[2]  = mk(0, 1, REG_PC, 16'h0040, 1, REG_LR, 16'h0010, 1, REG_PC, REG_LR, 4'd3,
                  BYP ? 16'h0040 : 16'h0000, BYP ? 16'h0010 : 16'h0000, 16'h1234, 16'h0000, 0);
    vecs[3]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, REG_PC, REG_LR, 4'd7,
                  16'h0040, 16'h0010, 16'h0000, 16'h0040, 0);
    vecs[4]  = mk(0, 1, 4'd7, 16'hAAAA, 1, 4'd7, 16'h5555, 0, 4'd7, REG_PC, 4'd1,
                  BYP ? 16'hAAAA : 16'h0000, 16'h0040, 16'h0000, 16'h0040, 0);
    vecs[5]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd7, REG_PC, REG_LR,
                  16'hAAAA, 16'h0040, 16'h0010, 16'h0040, 1);
    vecs[6]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd7, 4'd5, 4'd3,
                  16'hAAAA, 16'hBEEF, 16'h1234, 16'h0040, 0);
    vecs[7]  = mk(0, 0, 4'd0, 16'h0000, 1, REG_PC, 16'hFFFF, 0, REG_PC, 4'd7, 4'd0,
                  BYP ? 16'hFFFF : 16'h0040, 16'hAAAA, 16'h0000, 16'h0040, 0);
    vecs[8]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, REG_PC, 4'd0, 4'd0,
                  16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 0);
    for (int i = 9; i <= 12; i++)
      vecs[i] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, REG_PC, 4'd0, 4'd0,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[13] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, REG_PC, 4'd0, 4'd0,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[14] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, REG_PC, 4'd0, 4'd0,
                  16'h0001, 16'h0000, 16'h0000, 16'h0001, 0);
    vecs[15] = mk(0, 1, 4'd9, 16'h1111, 1, 4'd9, 16'h2222, 0, 4'd9, 4'd0, 4'd0,
                  BYP ? 16'h1111 : 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0);
    vecs[16] = mk(0, 1, 4'd9, 16'h3333, 1, 4'd9, 16'h4444, 0, 4'd9, 4'd0, 4'd0,
                  BYP ? 16'h3333 : 16'h1111, 16'h0000, 16'h0000, 16'h0001, 1);
    vecs[17] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd9, 4'd0, 4'd0,
                  16'h3333, 16'h0000, 16'h0000, 16'h0001, 1);
    vecs[18] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd9, 4'd0, 4'd0,
                  16'h3333, 16'h0000, 16'h0000, 16'h0001, 0);
    vecs[19] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd2, 16'h0ABC, 0, 4'd2, 4'd9, 4'd0,
                  BYP ? 16'h0ABC : 16'h0000, 16'h3333, 16'h0000, 16'h0001, 0);
    vecs[20] = mk(1, 1, 4'd2, 16'h00FF, 1, 4'd2, 16'h7777, 1, 4'd2, 4'd3, REG_PC,
                  BYP ? 16'h00FF : 16'h0ABC, 16'h1234, 16'h0001, 16'h0001, 0);
    vecs[21] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd2, 4'd3, REG_PC,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[22] = mk(0, 0, 4'd0, 16'h9999, 0, 4'd0, 16'h9999, 0, 4'd0, 4'd9, 4'd7,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    vecs[23] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd9, 4'd7,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

    // Reset sweep: every index on all three ports.
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.pc", bus.pc, 16'h0000);
    check("reset.collision", {15'd0, bus.collision}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.rd_addr_a = 4'(i);
      bus.rd_addr_b = 4'(i);
      bus.rd_addr_c = 4'(i);
      #1;
      check($sformatf("reset.r%0d.a", i), bus.rd_data_a, 16'h0000);
      check($sformatf("reset.r%0d.b", i), bus.rd_data_b, 16'h0000);
      check($sformatf("reset.r%0d.c", i), bus.rd_data_c, 16'h0000);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      bus.wr1       = vecs[i].w1;
      bus.wr_reg1   = vecs[i].r1;
      bus.wr_data1  = vecs[i].d1;
      bus.wr2       = vecs[i].w2;
      bus.wr_reg2   = vecs[i].r2;
      bus.wr_data2  = vecs[i].d2;
      bus.pc_inc    = vecs[i].inc;
      bus.rd_addr_a = vecs[i].ra;
      bus.rd_addr_b = vecs[i].rb;
      bus.rd_addr_c = vecs[i].rc;
      #1;
      check($sformatf("v%0d.rd_a", i), bus.rd_data_a, vecs[i].ea);
      check($sformatf("v%0d.rd_b", i), bus.rd_data_b, vecs[i].eb);
      check($sformatf("v%0d.rd_c", i), bus.rd_data_c, vecs[i].ec);
      check($sformatf("v%0d.pc", i), bus.pc, vecs[i].epc);
      check($sformatf("v%0d.collision", i), {15'd0, bus.collision}, {15'd0, vecs[i].ecol});
    end

    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
